// File: rtl/eth_frame_packer_if.sv
// Bundle of the FIFO-side read port and the Ethernet header/payload output port
// of eth_frame_packer. The master modport is the packer's view, the slave
// modport is the view of the surrounding FIFO/MAC logic.
interface eth_frame_packer_if #(
    parameter int COUNT_WIDTH = 12
);
    logic [7:0]             s_fifo_axis_tdata;
    logic                   s_fifo_axis_tvalid;
    logic                   s_fifo_axis_tready;
    logic [COUNT_WIDTH-1:0] s_fifo_rd_data_count;

    logic                   m_eth_hdr_valid;
    logic                   m_eth_hdr_ready;
    logic [47:0]            m_eth_dest_mac;
    logic [47:0]            m_eth_src_mac;
    logic [15:0]            m_eth_type;

    logic [7:0]             m_eth_payload_axis_tdata;
    logic                   m_eth_payload_axis_tvalid;
    logic                   m_eth_payload_axis_tready;
    logic                   m_eth_payload_axis_tlast;
    logic                   m_eth_payload_axis_tuser;

    modport master (
        input  s_fifo_axis_tdata, s_fifo_axis_tvalid, s_fifo_rd_data_count,
        output s_fifo_axis_tready,
        output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        input  m_eth_hdr_ready,
        output m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
        output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        input  m_eth_payload_axis_tready
    );

    modport slave (
        output s_fifo_axis_tdata, s_fifo_axis_tvalid, s_fifo_rd_data_count,
        input  s_fifo_axis_tready,
        input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        output m_eth_hdr_ready,
        input  m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
        input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        output m_eth_payload_axis_tready
    );
endinterface

// File: rtl/eth_frame_packer.sv
// Ethernet frame packer: waits for a full frame's worth of bytes in the source
// FIFO (or an idle timeout with a partial frame), raises one header, then emits
// a 4-byte sub-header {seq, len} followed by the FIFO bytes through a 2-entry
// registered skid buffer.
module eth_frame_packer #(
    parameter int          PAYLOAD_LEN    = 512,
    parameter int          COUNT_WIDTH    = 12,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [47:0] DEST_MAC       = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC        = 48'h020000000001,
    parameter logic [15:0] ETH_TYPE       = 16'h88B5
) (
    input  logic                 clk,
    input  logic                 rst,
    eth_frame_packer_if.master   bus,
    output logic [15:0]          status_seq_num
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    localparam logic [15:0]            FULL_LEN  = 16'(PAYLOAD_LEN);
    localparam logic [COUNT_WIDTH-1:0] FULL_CNT  = COUNT_WIDTH'(PAYLOAD_LEN);
    localparam int                     TIMER_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TIMER_W-1:0]     TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

    state_t               state_reg, state_next;
    logic                 hdr_valid_reg, hdr_valid_next;
    logic [1:0]           hdr_idx_reg, hdr_idx_next;
    logic [15:0]          remain_reg, remain_next;
    logic [15:0]          frame_len_reg, frame_len_next;
    logic [15:0]          seq_reg, seq_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;

    // Skid buffer: out_* is the registered output, skid_* catches one byte
    // when the downstream stalls. Input ready depends only on skid occupancy,
    // so downstream tready never reaches the FIFO read enable combinationally.
    logic                 out_valid_reg, out_last_reg;
    logic [7:0]           out_data_reg;
    logic                 skid_valid_reg, skid_last_reg;
    logic [7:0]           skid_data_reg;

    logic                 in_valid, in_last, in_ready, in_fire, fifo_ready;
    logic [7:0]           in_data;
    logic [COUNT_WIDTH-1:0] count;
    logic                 count_full, count_zero, timed_out;

    assign count      = bus.s_fifo_rd_data_count;
    assign count_full = (count >= FULL_CNT);
    assign count_zero = (count == '0);
    assign timed_out  = (TIMEOUT_CYCLES != 0) && (timer_reg == TIMER_MAX) && !count_zero;
    assign in_ready   = !skid_valid_reg;
    assign in_fire    = in_valid && in_ready;

    // Frame-control state and counters register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            hdr_valid_reg <= 1'b0;
            hdr_idx_reg   <= 2'd0;
            remain_reg    <= 16'd0;
            frame_len_reg <= 16'd0;
            seq_reg       <= 16'd0;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            hdr_valid_reg <= hdr_valid_next;
            hdr_idx_reg   <= hdr_idx_next;
            remain_reg    <= remain_next;
            frame_len_reg <= frame_len_next;
            seq_reg       <= seq_next;
            timer_reg     <= timer_next;
        end
    end

    // Next-state logic: start decision, sub-header sequencing, payload count-down.
    always_comb begin
        state_next     = state_reg;
        hdr_valid_next = hdr_valid_reg;
        hdr_idx_next   = hdr_idx_reg;
        remain_next    = remain_reg;
        frame_len_next = frame_len_reg;
        seq_next       = seq_reg;
        timer_next     = '0;
        in_valid       = 1'b0;
        in_data        = 8'd0;
        in_last        = 1'b0;
        fifo_ready     = 1'b0;

        if (hdr_valid_reg && bus.m_eth_hdr_ready) begin
            hdr_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (count_zero) begin
                    timer_next = '0;
                end else if (!count_full && timer_reg != TIMER_MAX) begin
                    timer_next = timer_reg + 1'b1;
                end else begin
                    timer_next = timer_reg;
                end
                if (!hdr_valid_reg && (count_full || timed_out)) begin
                    frame_len_next = count_full ? FULL_LEN : 16'(count);
                    hdr_valid_next = 1'b1;
                    hdr_idx_next   = 2'd0;
                    timer_next     = '0;
                    state_next     = HEADER;
                end
            end
            HEADER: begin
                in_valid = 1'b1;
                case (hdr_idx_reg)
                    2'd0:    in_data = seq_reg[15:8];
                    2'd1:    in_data = seq_reg[7:0];
                    2'd2:    in_data = frame_len_reg[15:8];
                    default: in_data = frame_len_reg[7:0];
                endcase
                if (in_ready) begin
                    hdr_idx_next = hdr_idx_reg + 2'd1;
                    if (hdr_idx_reg == 2'd3) begin
                        remain_next = frame_len_reg;
                        state_next  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                fifo_ready = in_ready;
                in_valid   = bus.s_fifo_axis_tvalid;
                in_data    = bus.s_fifo_axis_tdata;
                in_last    = (remain_reg == 16'd1);
                if (in_fire) begin
                    remain_next = remain_reg - 16'd1;
                    if (remain_reg == 16'd1) begin
                        seq_next   = seq_reg + 16'd1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output skid buffer: refill the output register from the skid slot first,
    // otherwise from the input; park the input byte when the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 8'd0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= 8'd0;
            skid_last_reg  <= 1'b0;
        end else if (!out_valid_reg || bus.m_eth_payload_axis_tready) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= skid_data_reg;
                out_last_reg   <= skid_last_reg;
                skid_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= in_fire;
                out_last_reg  <= in_fire && in_last;
                if (in_fire) begin
                    out_data_reg <= in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
            skid_last_reg  <= in_last;
        end
    end

    assign bus.s_fifo_axis_tready        = fifo_ready;
    assign bus.m_eth_hdr_valid           = hdr_valid_reg;
    assign bus.m_eth_dest_mac            = DEST_MAC;
    assign bus.m_eth_src_mac             = SRC_MAC;
    assign bus.m_eth_type                = ETH_TYPE;
    assign bus.m_eth_payload_axis_tdata  = out_data_reg;
    assign bus.m_eth_payload_axis_tvalid = out_valid_reg;
    assign bus.m_eth_payload_axis_tlast  = out_last_reg;
    assign bus.m_eth_payload_axis_tuser  = 1'b0;
    assign status_seq_num                = seq_reg;
endmodule

// File: doc/eth_frame_packer.md
Name: eth_frame_packer

Overview:
- Parametrised successor to the fixed 512-byte Ethernet packer.
- Drains an 8-bit AXI-Stream FIFO and emits one Ethernet header per frame on the eth_axis_tx-style header/payload interface.
- Each payload is a 4-byte sub-header (sequence number, payload length) followed by the data bytes.
- Adds occupancy-gated frame start, a timeout flush that sends a short frame, a per-frame sequence counter, and a registered skid-buffered payload output.

Parameters:
- PAYLOAD_LEN, 512: data bytes per full frame; legal range 1..1496.
- COUNT_WIDTH, 12: width of the FIFO read-count input; 2^COUNT_WIDTH must exceed PAYLOAD_LEN.
- TIMEOUT_CYCLES, 0: idle cycles before a partial frame is flushed; 0 disables flushing.
- DEST_MAC, 48'hFFFFFFFFFFFF: value driven on m_eth_dest_mac.
- SRC_MAC, 48'h020000000001: value driven on m_eth_src_mac.
- ETH_TYPE, 16'h88B5: value driven on m_eth_type.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_fifo_axis_tdata  in  8  FIFO data
- s_fifo_axis_tvalid  in  1  FIFO data valid
- s_fifo_axis_tready  out  1  FIFO read enable
- s_fifo_rd_data_count  in  COUNT_WIDTH  bytes currently in FIFO
- m_eth_hdr_valid  out  1  header valid
- m_eth_hdr_ready  in  1  header accepted
- m_eth_dest_mac  out  48  destination MAC
- m_eth_src_mac  out  48  source MAC
- m_eth_type  out  16  ethertype
- m_eth_payload_axis_tdata  out  8  payload byte
- m_eth_payload_axis_tvalid  out  1  payload valid
- m_eth_payload_axis_tready  in  1  payload ready
- m_eth_payload_axis_tlast  out  1  last payload byte of frame
- m_eth_payload_axis_tuser  out  1  tied 0 (no error source)
- status_seq_num  out  16  sequence number of the next frame to be sent

Behaviour:
- Reset (async, immediate): all valids/readys 0, tdata 0, tlast 0, status_seq_num 0, idle timer 0, state IDLE. MAC/type outputs take their parameter values. A frame in progress is abandoned without tlast.
- State IDLE:
  - Start condition: m_eth_hdr_valid==0 AND (count>=PAYLOAD_LEN OR (TIMEOUT_CYCLES!=0 AND timer==TIMEOUT_CYCLES AND count!=0)).
  - On start: latch frame_len = min(count, PAYLOAD_LEN), set m_eth_hdr_valid next cycle, go HEADER.
- Idle timer: increments in IDLE while 0<count<PAYLOAD_LEN and saturates at TIMEOUT_CYCLES. It clears on count==0, on frame start, and outside IDLE.
- Header handshake: m_eth_hdr_valid stays high until the cycle m_eth_hdr_ready is sampled high. MAC/type outputs are constant.
- State HEADER: emits 4 bytes into the output stage, one per cycle while the internal ready is high. Byte order:
  - seq[15:8], seq[7:0]
  - frame_len[15:8], frame_len[7:0]
  - After byte 3, go PAYLOAD.
- State PAYLOAD:
  - s_fifo_axis_tready = internal ready (registered early-ready). FIFO bytes pass straight through.
  - A 16-bit down-counter loads frame_len and decrements on each FIFO handshake.
  - The byte taken when the counter is 1 carries tlast=1. Then go IDLE and increment status_seq_num (wraps FFFF->0000).
- s_fifo_axis_tready is 0 in IDLE and HEADER.
- Starvation: if s_fifo_axis_tvalid drops mid-frame, the block stalls with no bubble, no error and no tlast until the remaining bytes arrive.
- Output stage: 2-entry skid buffer with registered outputs.
  - Sustains 1 byte/cycle when m_eth_payload_axis_tready is held high.
  - No combinational path from m_eth_payload_axis_tready to s_fifo_axis_tready.
  - No byte is lost or duplicated under any tready pattern.
- Latency: with the start decision registered at cycle N, m_eth_hdr_valid=1 at N+1. Sub-header byte 0 is valid on the output at N+2 when tready is held high.
- Back-to-back frames: the next start needs the previous header accepted and the state back in IDLE. A frame may start while its predecessor's last bytes are still in the skid buffer.
- Frame size: total payload is frame_len+4 bytes. Short frames below the Ethernet minimum are padded downstream, not here.

Test Plan:
1. PAYLOAD_LEN=512; preload 512 bytes of a 0x00..0xFF ramp; tready=1; hdr_ready=1 -> one hdr_valid pulse; 516 payload bytes; first 4 = 00 00 02 00; tlast only on byte 516; status_seq_num=1.
2. Same stimulus with random 50% payload tready -> byte sequence identical to test 1; no loss or duplicates; tvalid never drops while a byte is held.
3. TIMEOUT_CYCLES=100; push 10 bytes then stop -> frame starts 100 idle cycles later; sub-header 00 00 00 0A; 14 bytes; tlast on byte 14.
4. 1024 bytes preloaded; hdr_ready held low 50 cycles -> the second frame's hdr_valid is not raised until the first header is accepted; second sub-header seq = 00 01.
5. PAYLOAD_LEN=1; drive 65537 frames -> sequence fields run 0000..FFFF then 0000; each frame is 5 bytes.
6. Assert rst mid-PAYLOAD -> all outputs 0 in the same cycle, without a clock edge; after release, the next frame carries seq 0000.
